// File: rtl/phin_neural_processor.sv
// rtl/phin_neural_processor.sv - Q4.14 cortical-rhythm processor: theta plus six column oscillators, CA3 latch, DAC mix
// Seven magic-circle oscillators step on a 4 kHz strobe; gain-scaled layer outputs feed pattern, CA3 and DAC logic.
module phin_neural_processor #(
  parameter int WIDTH    = 18,
  parameter int FRAC     = 14,
  parameter int FAST_SIM = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] sensory_input,
  input  logic [2:0]              state_select,
  input  logic signed [WIDTH-1:0] sr_field_input,
  input  logic [5*WIDTH-1:0]      sr_field_packed,
  output logic [11:0]             dac_output,
  output logic signed [WIDTH-1:0] debug_motor_l23,
  output logic signed [WIDTH-1:0] debug_theta,
  output logic                    ca3_learning,
  output logic                    ca3_recalling,
  output logic [5:0]              ca3_phase_pattern,
  output logic [5:0]              cortical_pattern_out
);
  localparam int LW  = 2*WIDTH;
  localparam int DIV = (FAST_SIM != 0) ? 10 : 31250;
  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic signed [LW-1:0] SAT_MAX = (LW'(1) <<< (WIDTH-1)) - LW'(1);
  localparam logic signed [LW-1:0] SAT_MIN = -SAT_MAX - LW'(1);
  localparam logic signed [WIDTH-1:0] ONE         = WIDTH'(1 << FRAC);
  localparam logic signed [WIDTH-1:0] THETA_HI    = WIDTH'(12000);
  localparam logic signed [WIDTH-1:0] THETA_LO    = WIDTH'(-12000);
  localparam logic signed [WIDTH-1:0] SENS_LEARN  = WIDTH'(10000);
  localparam logic signed [WIDTH-1:0] SENS_RECALL = WIDTH'(4000);

  function automatic logic signed [LW-1:0] ext(input logic signed [WIDTH-1:0] a);
    return {{WIDTH{a[WIDTH-1]}}, a};
  endfunction

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [LW-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    else return v[WIDTH-1:0];
  endfunction

  function automatic logic signed [LW-1:0] gain(input logic signed [WIDTH-1:0] a, input logic [2:0] mu);
    return (ext(a) * $signed({{(LW-3){1'b0}}, mu})) >>> 2;
  endfunction

  // Index map: 0 theta, 1/2 sensory L6/L23, 3/4 assoc L6/L23, 5/6 motor L6/L23
  function automatic int osc_k(input int i);
    if (i == 0) return 6;
    else if ((i % 2) == 1) return 5;
    else return 3;
  endfunction

  function automatic logic signed [WIDTH-1:0] seed_x(input int i);
    if (i <= 2) return ONE;
    else if (i <= 4) return '0;
    else return -ONE;
  endfunction

  function automatic logic signed [WIDTH-1:0] seed_y(input int i);
    return (i == 3 || i == 4) ? ONE : '0;
  endfunction

  function automatic logic is_pos(input logic signed [WIDTH-1:0] a);
    return !a[WIDTH-1] && (a != '0);
  endfunction

  logic [15:0]             div_cnt;
  logic                    clk_4khz_en;
  logic [2:0]              mu_dt_theta, mu_dt_l6, mu_dt_l23;
  logic [2:0]              g_theta, g_l6, g_l23;
  logic signed [WIDTH-1:0] osc_x [7];
  logic signed [WIDTH-1:0] osc_y [7];
  logic signed [WIDTH-1:0] nx [7];
  logic signed [WIDTH-1:0] ny [7];
  logic signed [LW-1:0]    inj [7];
  logic signed [LW-1:0]    sr_sum;
  logic signed [WIDTH-1:0] theta_x;
  logic signed [WIDTH-1:0] sensory_l6_x, sensory_l23_x, assoc_l6_x, assoc_l23_x, motor_l6_x, motor_l23_x;
  logic signed [WIDTH-1:0] theta_couple_base, phase_couple_sensory_l23, phase_couple_motor_l6;
  logic signed [LW-1:0]    dac_sum;
  logic [11:0]             dac_next;
  logic                    learn_now, recall_now, ca3_valid;
  logic [5:0]              ca3_memory;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt     <= '0;
      clk_4khz_en <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt     <= '0;
      clk_4khz_en <= 1'b1;
    end else begin
      div_cnt     <= div_cnt + 16'd1;
      clk_4khz_en <= 1'b0;
    end
  end

  always_comb begin
    {g_theta, g_l6, g_l23} = {3'd4, 3'd4, 3'd4};
    case (state_select)
      3'd1:    {g_theta, g_l6, g_l23} = {3'd2, 3'd2, 3'd1};
      3'd2:    {g_theta, g_l6, g_l23} = {3'd4, 3'd6, 3'd6};
      3'd3:    {g_theta, g_l6, g_l23} = {3'd4, 3'd4, 3'd5};
      3'd4:    {g_theta, g_l6, g_l23} = {3'd4, 3'd4, 3'd2};
      default: ;
    endcase
  end

  always_comb begin
    sr_sum = '0;
    for (int j = 0; j < 5; j++) sr_sum = sr_sum + ext(sr_field_packed[j*WIDTH +: WIDTH]);
    for (int i = 0; i < 7; i++) inj[i] = '0;
    inj[1] = ext(sr_field_input) >>> 6;
    inj[3] = sr_sum >>> 8;
    for (int i = 0; i < 7; i++) begin
      nx[i] = sat(ext(osc_x[i]) - (ext(osc_y[i]) >>> osc_k(i)));
      ny[i] = sat(ext(osc_y[i]) + (ext(nx[i]) >>> osc_k(i)) + inj[i]);
    end
  end

  assign theta_couple_base        = theta_x >>> 2;
  assign phase_couple_sensory_l23 = theta_couple_base >>> 1;
  assign phase_couple_motor_l6    = sat(-(ext(theta_couple_base) >>> 1));

  assign cortical_pattern_out = {is_pos(sensory_l6_x), is_pos(sensory_l23_x), is_pos(assoc_l6_x),
                                 is_pos(assoc_l23_x), is_pos(motor_l6_x), is_pos(motor_l23_x)};

  // Learning takes priority, so recall is masked whenever the encode window is open
  assign learn_now  = (theta_x > THETA_HI) && (sensory_input >= SENS_LEARN);
  assign recall_now = ca3_valid && (theta_x < THETA_LO) && (sensory_input >= SENS_RECALL) &&
                      (sensory_input < SENS_LEARN) && !learn_now;

  always_comb begin
    dac_sum = LW'(2048) + ((ext(motor_l23_x) + ext(theta_x)) >>> 5);
    if (dac_sum < LW'(0)) dac_next = 12'd0;
    else if (dac_sum > LW'(4095)) dac_next = 12'd4095;
    else dac_next = dac_sum[11:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 7; i++) begin
        osc_x[i] <= seed_x(i);
        osc_y[i] <= seed_y(i);
      end
      mu_dt_theta       <= 3'd4;
      mu_dt_l6          <= 3'd4;
      mu_dt_l23         <= 3'd4;
      theta_x           <= '0;
      sensory_l6_x      <= '0;
      sensory_l23_x     <= '0;
      assoc_l6_x        <= '0;
      assoc_l23_x       <= '0;
      motor_l6_x        <= '0;
      motor_l23_x       <= '0;
      dac_output        <= 12'd2048;
      ca3_learning      <= 1'b0;
      ca3_recalling     <= 1'b0;
      ca3_phase_pattern <= '0;
      ca3_memory        <= '0;
      ca3_valid         <= 1'b0;
    end else if (clk_4khz_en) begin
      for (int i = 0; i < 7; i++) begin
        osc_x[i] <= nx[i];
        osc_y[i] <= ny[i];
      end
      mu_dt_theta   <= g_theta;
      mu_dt_l6      <= g_l6;
      mu_dt_l23     <= g_l23;
      theta_x       <= sat(gain(osc_x[0], mu_dt_theta));
      sensory_l6_x  <= sat(gain(osc_x[1], mu_dt_l6));
      sensory_l23_x <= sat(gain(osc_x[2], mu_dt_l23) + (ext(phase_couple_sensory_l23) >>> 2) +
                           (ext(sensory_input) >>> 2));
      assoc_l6_x    <= sat(gain(osc_x[3], mu_dt_l6));
      assoc_l23_x   <= sat(gain(osc_x[4], mu_dt_l23));
      motor_l6_x    <= sat(gain(osc_x[5], mu_dt_l6) + (ext(phase_couple_motor_l6) >>> 2));
      motor_l23_x   <= sat(gain(osc_x[6], mu_dt_l23));
      dac_output    <= dac_next;
      ca3_learning  <= learn_now;
      ca3_recalling <= recall_now;
      if (learn_now) begin
        ca3_memory <= cortical_pattern_out;
        ca3_valid  <= 1'b1;
      end
      if (recall_now) ca3_phase_pattern <= ca3_memory;
    end
  end

  assign debug_theta     = theta_x;
  assign debug_motor_l23 = motor_l23_x;

endmodule

// File: tb/tb_phin_neural_processor.sv
// tb/tb_phin_neural_processor.sv - self-checking bench for phin_neural_processor (FAST_SIM strobe)
// An integer reference model steps the seven oscillators and derived outputs once per strobe.
module tb_phin_neural_processor;
  localparam int W = 18;

  logic                clk = 1'b0;
  logic                rst;
  logic signed [W-1:0] sensory_input;
  logic [2:0]          state_select;
  logic signed [W-1:0] sr_field_input;
  logic [5*W-1:0]      sr_field_packed;
  logic [11:0]         dac_output;
  logic signed [W-1:0] debug_motor_l23;
  logic signed [W-1:0] debug_theta;
  logic                ca3_learning;
  logic                ca3_recalling;
  logic [5:0]          ca3_phase_pattern;
  logic [5:0]          cortical_pattern_out;

  int checks = 0;
  int fails  = 0;

  always #4 clk = ~clk;

  phin_neural_processor #(.WIDTH(W), .FRAC(14), .FAST_SIM(1)) dut (
    .clk(clk), .rst(rst), .sensory_input(sensory_input), .state_select(state_select),
    .sr_field_input(sr_field_input), .sr_field_packed(sr_field_packed), .dac_output(dac_output),
    .debug_motor_l23(debug_motor_l23), .debug_theta(debug_theta), .ca3_learning(ca3_learning),
    .ca3_recalling(ca3_recalling), .ca3_phase_pattern(ca3_phase_pattern),
    .cortical_pattern_out(cortical_pattern_out)
  );

  wire [61:0] dut_vec = {debug_theta, debug_motor_l23, dac_output, cortical_pattern_out,
                         ca3_learning, ca3_recalling, ca3_phase_pattern};

  // Reference model: index 0 theta, 1/2 sensory L6/L23, 3/4 assoc, 5/6 motor
  int ox [7];
  int oy [7];
  int lay [7];
  int mt, m6, m23, mdac, mmem, mcpat;
  bit mlearn, mrecall, mvalid;
  int tab_t [8]   = '{4, 2, 4, 4, 4, 4, 4, 4};
  int tab_6 [8]   = '{4, 2, 6, 4, 4, 4, 4, 4};
  int tab_23 [8]  = '{4, 1, 6, 5, 2, 4, 4, 4};

  function automatic int sat18(longint v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return int'(v);
  endfunction

  function automatic int model_pattern();
    int p = 0;
    for (int i = 1; i < 7; i++) if (lay[i] > 0) p = p | (1 << (6 - i));
    return p;
  endfunction

  function automatic logic [61:0] exp_vec();
    return {18'(lay[0]), 18'(lay[6]), 12'(mdac), 6'(model_pattern()), mlearn, mrecall, 6'(mcpat)};
  endfunction

  task automatic model_reset();
    ox = '{16384, 16384, 16384, 0, 0, -16384, -16384};
    oy = '{0, 0, 0, 16384, 16384, 0, 0};
    lay = '{0, 0, 0, 0, 0, 0, 0};
    mt = 4; m6 = 4; m23 = 4; mdac = 2048; mmem = 0; mcpat = 0;
    mlearn = 0; mrecall = 0; mvalid = 0;
  endtask

  task automatic model_step();
    int s, sum, pat, tcb, pcs, pcm, k, g, nxv, inj, d;
    int nl [7];
    bit l, r;
    s = int'(sensory_input);
    sum = 0;
    for (int j = 0; j < 5; j++) begin
      logic signed [W-1:0] f;
      f = sr_field_packed[j*W +: W];
      sum += int'(f);
    end
    pat = model_pattern();
    tcb = lay[0] >>> 2;
    pcs = tcb >>> 1;
    pcm = -(tcb >>> 1);
    for (int i = 0; i < 7; i++) begin
      g = (i == 0) ? mt : ((i % 2 == 1) ? m6 : m23);
      nl[i] = (ox[i] * g) >>> 2;
      if (i == 2) nl[i] += (pcs >>> 2) + (s >>> 2);
      if (i == 5) nl[i] += (pcm >>> 2);
      nl[i] = sat18(nl[i]);
    end
    d = 2048 + ((lay[6] + lay[0]) >>> 5);
    mdac = (d < 0) ? 0 : ((d > 4095) ? 4095 : d);
    l = (lay[0] > 12000) && (s >= 10000);
    r = mvalid && (lay[0] < -12000) && (s >= 4000) && (s < 10000) && !l;
    if (l) begin mmem = pat; mvalid = 1; end
    if (r) mcpat = mmem;
    mlearn = l; mrecall = r;
    for (int i = 0; i < 7; i++) begin
      k = (i == 0) ? 6 : ((i % 2 == 1) ? 5 : 3);
      inj = (i == 1) ? (int'(sr_field_input) >>> 6) : ((i == 3) ? (sum >>> 8) : 0);
      nxv = sat18(longint'(ox[i]) - (oy[i] >>> k));
      oy[i] = sat18(longint'(oy[i]) + (nxv >>> k) + inj);
      ox[i] = nxv;
    end
    mt = tab_t[state_select]; m6 = tab_6[state_select]; m23 = tab_23[state_select];
    lay = nl;
  endtask

  task automatic strobe();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!dut.clk_4khz_en && guard < 40);
    checks++;
    if (!dut.clk_4khz_en) begin
      fails++;
      $display("FAIL strobe_timeout: no strobe after %0d clocks, required within 10", guard);
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(int sens, int st);
    sensory_input = W'(sens);
    state_select = 3'(st);
    sr_field_input = '0;
    sr_field_packed = '0;
  endtask

  task automatic test_reset();
    int n = 0;
    set_inputs(0, 0);
    rst = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (dac_output !== 12'd2048) begin fails++; $display("FAIL reset_dac: got %0d expected 2048", dac_output); end
    if (debug_theta !== '0 || debug_motor_l23 !== '0) begin
      fails++; $display("FAIL reset_debug: theta %0d motor %0d expected 0", debug_theta, debug_motor_l23);
    end
    if ({ca3_learning, ca3_recalling, ca3_phase_pattern} !== 8'd0) begin
      fails++; $display("FAIL reset_ca3: got %b expected 0", {ca3_learning, ca3_recalling, ca3_phase_pattern});
    end
    if (cortical_pattern_out !== 6'd0) begin fails++; $display("FAIL reset_pattern: got %b expected 0", cortical_pattern_out); end
    rst = 1'b0;
    model_reset();
    set_inputs(4096, 0);
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!dut.clk_4khz_en && n < 40);
    checks++;
    if (n != 10) begin fails++; $display("FAIL first_strobe_latency: got %0d clocks expected 10", n); end
  endtask

  task automatic test_oscillate();
    for (int n = 0; n < 500; n++) begin
      strobe();
      checks++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL osc_track strobe %0d: got %h expected %h", n, dut_vec, exp_vec()); end
    end
    checks++;
    if (debug_theta === '0 || debug_motor_l23 === '0) begin
      fails++; $display("FAIL osc_nonzero: theta %0d motor %0d expected both nonzero", debug_theta, debug_motor_l23);
    end
  endtask

  task automatic test_theta_crossings();
    int dut_cnt = 0, ref_cnt = 0;
    bit dut_arm = 1, ref_arm = 1;
    set_inputs(0, 0);
    for (int n = 0; n < 2000; n++) begin
      strobe();
      checks++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL theta_track strobe %0d: got %h expected %h", n, dut_vec, exp_vec()); end
      if (dut_arm && debug_theta > 12000) begin dut_cnt++; dut_arm = 0; end
      if (debug_theta < 8000) dut_arm = 1;
      if (ref_arm && lay[0] > 12000) begin ref_cnt++; ref_arm = 0; end
      if (lay[0] < 8000) ref_arm = 1;
    end
    checks += 2;
    if (dut_cnt < 1) begin fails++; $display("FAIL theta_cross_min: got %0d expected >= 1", dut_cnt); end
    if (dut_cnt != ref_cnt) begin fails++; $display("FAIL theta_cross_count: got %0d expected %0d", dut_cnt, ref_cnt); end
  endtask

  task automatic test_dac_swing();
    int lo = 4096, hi = -1;
    for (int n = 0; n < 1000; n++) begin
      strobe();
      checks++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL dac_track strobe %0d: got %h expected %h", n, dut_vec, exp_vec()); end
      if (int'(dac_output) < lo) lo = int'(dac_output);
      if (int'(dac_output) > hi) hi = int'(dac_output);
    end
    checks++;
    if (hi - lo <= 500) begin fails++; $display("FAIL dac_swing: got %0d expected > 500", hi - lo); end
  endtask

  task automatic test_ca3();
    int n = 0;
    set_inputs(12000, 0);
    do begin strobe(); n++; end while (!ca3_learning && n < 500);
    checks += 2;
    if (!ca3_learning) begin fails++; $display("FAIL ca3_learn: no learning in %0d strobes, required within 500", n); end
    if (dut_vec !== exp_vec()) begin fails++; $display("FAIL ca3_learn_state: got %h expected %h", dut_vec, exp_vec()); end
    set_inputs(8000, 0);
    n = 0;
    do begin strobe(); n++; end while (!ca3_recalling && n < 500);
    checks += 2;
    if (!ca3_recalling) begin fails++; $display("FAIL ca3_recall: no recall in %0d strobes, required within 500", n); end
    if (ca3_phase_pattern !== 6'(mmem)) begin
      fails++; $display("FAIL ca3_pattern: got %b expected %b", ca3_phase_pattern, 6'(mmem));
    end
  endtask

  task automatic test_meditation();
    set_inputs(0, 4);
    for (int n = 0; n < 100; n++) strobe();
    checks += 4;
    if (dut.mu_dt_theta !== 3'(mt) || mt != 4) begin fails++; $display("FAIL medit_mu_theta: got %0d expected 4", dut.mu_dt_theta); end
    if (dut.mu_dt_l23 !== 3'(m23) || m23 != 2) begin fails++; $display("FAIL medit_mu_l23: got %0d expected 2", dut.mu_dt_l23); end
    if (dut.theta_couple_base === '0) begin fails++; $display("FAIL medit_couple: got 0 expected nonzero"); end
    if (dut_vec !== exp_vec()) begin fails++; $display("FAIL medit_track: got %h expected %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_back_to_back();
    set_inputs(4096, 0);
    for (int n = 0; n < 200; n++) strobe();
    checks += 2;
    if (dut.sensory_l23_x === '0 || dut.assoc_l23_x === '0 || dut.motor_l23_x === '0) begin
      fails++; $display("FAIL normal_l23_nonzero: got %0d %0d %0d expected all nonzero",
                        dut.sensory_l23_x, dut.assoc_l23_x, dut.motor_l23_x);
    end
    if (dut_vec !== exp_vec()) begin fails++; $display("FAIL normal_track: got %h expected %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      int r;
      r = int'($urandom_range(0, 40000)) - 20000;
      sensory_input = r[W-1:0];
      state_select = 3'($urandom_range(0, 7));
      r = int'($urandom_range(0, 6000)) - 3000;
      sr_field_input = r[W-1:0];
      for (int j = 0; j < 5; j++) begin
        r = int'($urandom_range(0, 6000)) - 3000;
        sr_field_packed[j*W +: W] = r[W-1:0];
      end
      strobe();
      checks++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL random_track strobe %0d: got %h expected %h", n, dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_reset_midrun();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks += 3;
    if (dac_output !== 12'd2048 || debug_theta !== '0 || debug_motor_l23 !== '0) begin
      fails++; $display("FAIL midrun_reset_out: dac %0d theta %0d motor %0d expected 2048 0 0", dac_output, debug_theta, debug_motor_l23);
    end
    if ({ca3_learning, ca3_recalling, ca3_phase_pattern, cortical_pattern_out} !== 14'd0) begin
      fails++; $display("FAIL midrun_reset_ca3: got %b expected 0", {ca3_learning, ca3_recalling, ca3_phase_pattern, cortical_pattern_out});
    end
    if (dut.osc_x[0] !== 18'sd16384 || dut.osc_y[3] !== 18'sd16384 || dut.osc_x[6] !== -18'sd16384) begin
      fails++; $display("FAIL midrun_reseed: got %0d %0d %0d expected 16384 16384 -16384", dut.osc_x[0], dut.osc_y[3], dut.osc_x[6]);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    set_inputs(4096, 0);
    for (int n = 0; n < 50; n++) begin
      strobe();
      checks++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL post_reset_track strobe %0d: got %h expected %h", n, dut_vec, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_oscillate();
    test_theta_crossings();
    test_dac_swing();
    test_ca3();
    test_meditation();
    test_back_to_back();
    test_random();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
